up_down_sweeper: RTL and testbench
==================================

# up_down_sweeper

Direction controller and self-checker for the `up_down_counter` block. It drives the counter's `d` input and watches its `count` output. On `start` it steers the free-running counter into a programmed window `[lo, hi]` and ping-pongs it between the bounds for a given number of turnarounds. In parallel it predicts every count value and flags any deviation. It connects to the same `up_down` interface signals (`d`, `count`) and shares `clk`/`rst` with the counter.

## Interface
- `WIDTH`, default 4: width of `count`, `lo`, `hi`.
- `clk`  in  1  rising-edge clock; the same clock as the counter.
- `rst`  in  1  reset, synchronous, active-high; the same reset as the counter.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `stop`  in  1  abort an active sweep.
- `lo`, `hi`  in  WIDTH  window bounds; sampled on an accepted `start`.
- `sweeps`  in  8  number of turnarounds to run; sampled on `start`; 0 means run until `stop`.
- `count`  in  WIDTH  counter value under observation.
- `d`  out  1  direction to the counter: 1 = up, 0 = down; registered.
- `busy`  out  1  high in `SEEK`, `UP` and `DOWN`.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `cfg_err`  out  1  one-cycle pulse when a `start` is rejected.
- `err`  out  1  sticky mismatch flag; cleared by `rst` or by an accepted `start`.

## Operation
- Counter model: each edge, `count <= rst ? 0 : (d ? count+1 : count-1)`, wrapping mod 2^WIDTH. The counter counts every cycle and has no hold.
- States: `IDLE`, `SEEK`, `UP`, `DOWN`.
- `IDLE`: `d=1` and the counter free-runs.
  - `start` with `hi > lo`: latch `lo`, `hi`, `sweeps`; clear `err` and the turnaround count; go to `SEEK`.
  - `start` with `hi <= lo`: pulse `cfg_err`; stay in `IDLE`.
- `SEEK`: `d=1`. At the edge where `count == lo-1` (mod 2^WIDTH), go to `UP` and set `exp <= lo`.
- `UP`: at the edge where `count == hi-1`, set `d <= 0`, go to `DOWN`, and increment the turnaround count.
- `DOWN`: at the edge where `count == lo+1`, set `d <= 1`, go to `UP`, and increment the turnaround count.
- Completion: when the increment makes the turnaround count equal `sweeps` (with `sweeps != 0`), go to `IDLE`, set `d <= 1`, and pulse `done`.
- Checker (active in `UP`/`DOWN` only):
  - Each cycle, if `count != exp` then `err <= 1`.
  - Each edge, `exp <= d ? exp+1 : exp-1`, using the `d` value in force at that edge.
- `stop` in `SEEK`/`UP`/`DOWN`: go to `IDLE` and set `d <= 1`. No `done` pulse. `err` is held.
- `stop` and a completing turnaround in the same cycle: `stop` wins and no `done` is pulsed.
- `hi == lo+1`: a turnaround occurs on every edge. This is legal.
- Arithmetic: `lo-1`, `lo+1`, `hi-1` and `exp` are all WIDTH bits and wrap.
- The turnaround counter is 8 bits and is never compared when `sweeps == 0`.

## Timing
- Reset values: `IDLE`, `d=1`, `busy=0`, `done=0`, `cfg_err=0`, `err=0`, `exp=0`, turnaround count 0.
- `rst` asserted mid-sweep returns the block to the reset state on the next edge. The counter returns to 0 on the same edge.
- `start` accepted at edge T: `busy=1` from T.
- `SEEK` latency: 1 to 2^WIDTH cycles, depending on `count` at acceptance.
- `d` changes exactly one edge before the counter reverses. With `d=1`, `count` reaches `hi` and then decrements on the next edge, so the counter never leaves `[lo, hi]` while in `UP`/`DOWN`.
- `done` and `cfg_err` are registered, high for exactly one cycle following the deciding edge. `busy` falls on the same edge at which `done` rises.
- `err` sets on the edge following the first mismatching cycle.

## Structure
- Package `up_down_pkg`:
  - state enum `sweep_state_t`;
  - constants `DIR_UP = 1'b1`, `DIR_DOWN = 1'b0`.
- Sub-module `up_down_predictor` holds `exp` and the mismatch compare, with inputs load/lo/d/count/en and output `err`.
- The FSM and turnaround counter live in the top module.

## Test plan
All scenarios use WIDTH=4, with the counter instantiated alongside the block.
- Reset, then `start` at count 0 with `lo=3, hi=6, sweeps=4`:
  - `count` runs 1,2,3,4,5,6,5,4,3,4,5,6,5,4,3,4;
  - `d` falls at count 5 and rises at count 4;
  - `done` pulses once; `err=0` throughout.
- `lo=14, hi=15, sweeps=3`: `count` alternates 14,15,14,15 and `done` pulses after the 3rd turnaround.
- `lo=9, hi=9` and `lo=10, hi=4`: `cfg_err` pulses one cycle each time, `busy` stays 0, and `d` stays 1.
- Force `count` to 0 for one cycle mid-`UP` with `lo=2, hi=12, sweeps=0`: `err=1` on the next cycle and stays high; a later accepted `start` clears it.
- `stop` asserted in `DOWN`: next edge `busy=0`, `d=1`, no `done`; the counter resumes counting up.
- `rst` pulsed mid-sweep: next edge `count=0`, `d=1`, `busy=0`, `err=0`; a new `start` then completes normally.

Source files
------------

// File: rtl/up_down_pkg.sv
// Shared types and constants for the up/down counter sweeper.
package up_down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } sweep_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/up_down_predictor.sv
// Shadow model of the up/down counter: tracks the expected count and raises a
// sticky error on the first cycle the observed count differs from it.
module up_down_predictor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] lo,
  input  logic             d,
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  // Load seeds the prediction and clears the error; while enabled, compare and
  // step the prediction with the direction the counter sees at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      exp_q <= lo;
      err_q <= 1'b0;
    end else if (en) begin
      if (count != exp_q) begin
        err_q <= 1'b1;
      end
      exp_q <= d ? (exp_q + ONE) : (exp_q - ONE);
    end
  end

  assign err = err_q;

endmodule

// File: rtl/up_down_sweeper.sv
// Steers a free-running up/down counter into [lo, hi], ping-pongs it for a
// programmed number of turnarounds and checks every count value on the way.
//
// Handshake: start is a single-cycle request, accepted only in IDLE; it has no
// ready side, so a start while busy is simply dropped. done and cfg_err are
// single-cycle registered pulses; stop is level-sampled each cycle.
module up_down_sweeper
  import up_down_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [7:0]       sweeps,
  input  logic [WIDTH-1:0] count,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             err,
  output sweep_state_t     dbg_state
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  sweep_state_t     state_q;
  logic             d_q;
  logic             done_q;
  logic             cfg_err_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [7:0]       sweeps_q;
  logic [7:0]       turn_q;

  logic [WIDTH-1:0] lo_m1;
  logic [WIDTH-1:0] lo_p1;
  logic [WIDTH-1:0] hi_m1;
  logic [7:0]       turn_d;
  logic             completing;
  logic             accept;
  logic             seek_hit;
  logic             pred_load;
  logic [WIDTH-1:0] pred_lo;
  logic             pred_en;

  // Turnaround thresholds, the completion test and predictor control.
  always_comb begin
    lo_m1      = lo_q - ONE;
    lo_p1      = lo_q + ONE;
    hi_m1      = hi_q - ONE;
    turn_d     = turn_q + 8'd1;
    completing = (sweeps_q != 8'd0) && (turn_d == sweeps_q);
    accept     = (state_q == ST_IDLE) && start && (hi > lo);
    seek_hit   = (state_q == ST_SEEK) && !stop && (count == lo_m1);
    // Seed with the raw input on accept (lo_q is not yet valid), then re-seed
    // from the latched bound when the counter enters the window.
    pred_load  = accept || seek_hit;
    pred_lo    = accept ? lo : lo_q;
    pred_en    = (state_q == ST_UP) || (state_q == ST_DOWN);
  end

  // Sweep FSM with registered direction, pulses and turnaround counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      d_q       <= DIR_UP;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      sweeps_q  <= 8'd0;
      turn_q    <= 8'd0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          d_q <= DIR_UP;
          if (start) begin
            if (hi > lo) begin
              lo_q     <= lo;
              hi_q     <= hi;
              sweeps_q <= sweeps;
              turn_q   <= 8'd0;
              state_q  <= ST_SEEK;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_SEEK: begin
          d_q <= DIR_UP;
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (count == lo_m1) begin
            state_q <= ST_UP;
          end
        end
        ST_UP: begin
          if (stop) begin
            state_q <= ST_IDLE;
            d_q     <= DIR_UP;
          end else if (count == hi_m1) begin
            turn_q <= turn_d;
            if (completing) begin
              state_q <= ST_IDLE;
              d_q     <= DIR_UP;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DOWN;
              d_q     <= DIR_DOWN;
            end
          end
        end
        ST_DOWN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            d_q     <= DIR_UP;
          end else if (count == lo_p1) begin
            turn_q <= turn_d;
            d_q    <= DIR_UP;
            if (completing) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_UP;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          d_q     <= DIR_UP;
        end
      endcase
    end
  end

  up_down_predictor #(.WIDTH(WIDTH)) u_pred (
    .clk   (clk),
    .rst   (rst),
    .load  (pred_load),
    .lo    (pred_lo),
    .d     (d_q),
    .count (count),
    .en    (pred_en),
    .err   (err)
  );

  assign d         = d_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_up_down_sweeper.sv
// Directed bench for up_down_sweeper driving a behavioural up/down counter.
module tb_up_down_sweeper;
  import up_down_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [7:0]   sweeps;
  logic [W-1:0] cnt;
  logic [W-1:0] count;
  logic         force_zero;
  logic         d;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic         err;
  sweep_state_t dbg_state;

  int checks;
  int failures;

  // Hand-computed traces for the first sweep (lo=3, hi=6, sweeps=4 from count 0).
  int s1_cnt [16] = '{1,2,3,4,5,6,5,4,3,4,5,6,5,4,3,4};
  int s1_d   [16] = '{1,1,1,1,1,0,0,0,1,1,1,0,0,0,1,1};
  int s1_busy[16] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
  int s1_done[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
  // lo=14, hi=15, sweeps=3 started at count 4.
  int s2_cnt [14] = '{5,6,7,8,9,10,11,12,13,14,15,14,15,0};
  int s2_d   [14] = '{1,1,1,1,1,1,1,1,1,1,0,1,1,1};
  int s2_busy[14] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0};
  int s2_done[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0};
  // lo=3, hi=6, sweeps=1 after reset.
  int s6_cnt [7]  = '{1,2,3,4,5,6,7};
  int s6_done[7]  = '{0,0,0,0,0,1,0};

  // Clock and reference counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cnt <= rst ? '0 : (d ? cnt + 4'd1 : cnt - 4'd1);
  end
  assign count = force_zero ? '0 : cnt;

  up_down_sweeper #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .lo        (lo),
    .hi        (hi),
    .sweeps    (sweeps),
    .count     (count),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input sweep_state_t target, input int max_cyc);
    int n;
    n = 0;
    while (dbg_state != target && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, dbg_state, target);
  endtask

  task automatic request(input logic [W-1:0] l, input logic [W-1:0] h, input logic [7:0] s);
    lo     = l;
    hi     = h;
    sweeps = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    logic err_seen;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    lo         = '0;
    hi         = '0;
    sweeps     = 8'd0;
    force_zero = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_count", count, 0);
    check("rst_d", d, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_err", err, 0);

    // Basic sweep from count 0.
    err_seen = 1'b0;
    request(4'd3, 4'd6, 8'd4);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      check($sformatf("s1_count[%0d]", i), count, s1_cnt[i]);
      check($sformatf("s1_d[%0d]", i), d, s1_d[i]);
      check($sformatf("s1_busy[%0d]", i), busy, s1_busy[i]);
      check($sformatf("s1_done[%0d]", i), done, s1_done[i]);
      err_seen = err_seen | err;
    end
    check("s1_err_never", err_seen, 0);

    // Narrowest window: a turnaround on every edge.
    request(4'd14, 4'd15, 8'd3);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      check($sformatf("s2_count[%0d]", i), count, s2_cnt[i]);
      check($sformatf("s2_d[%0d]", i), d, s2_d[i]);
      check($sformatf("s2_busy[%0d]", i), busy, s2_busy[i]);
      check($sformatf("s2_done[%0d]", i), done, s2_done[i]);
    end
    check("s2_err", err, 0);

    // Rejected configurations.
    request(4'd9, 4'd9, 8'd2);
    check("cfg_eq_pulse", cfg_err, 1);
    check("cfg_eq_busy", busy, 0);
    check("cfg_eq_d", d, 1);
    tick();
    check("cfg_eq_clear", cfg_err, 0);
    request(4'd10, 4'd4, 8'd2);
    check("cfg_lt_pulse", cfg_err, 1);
    check("cfg_lt_busy", busy, 0);
    check("cfg_lt_d", d, 1);
    tick();
    check("cfg_lt_clear", cfg_err, 0);
    check("cfg_lt_busy2", busy, 0);

    // Injected mismatch mid-UP with an endless sweep.
    request(4'd2, 4'd12, 8'd0);
    wait_state("s4_reach_up", ST_UP, 20);
    check("s4_up_entry_count", count, 2);
    tick();
    tick();
    check("s4_err_before", err, 0);
    force_zero = 1'b1;
    tick();
    force_zero = 1'b0;
    check("s4_err_set", err, 1);
    tick();
    tick();
    check("s4_err_sticky", err, 1);

    // Stop in DOWN: no done, direction back to up, err held.
    wait_state("s5_reach_down", ST_DOWN, 20);
    check("s5_down_count", count, 12);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s5_busy", busy, 0);
    check("s5_d", d, 1);
    check("s5_done", done, 0);
    check("s5_err_held", err, 1);
    check("s5_count", count, 11);
    tick();
    check("s5_count_up", count, 12);
    check("s5_no_done_late", done, 0);

    // A new accepted start clears err; then reset mid-sweep.
    request(4'd1, 4'd3, 8'd2);
    check("s6_err_cleared", err, 0);
    check("s6_busy", busy, 1);
    wait_state("s6_reach_up", ST_UP, 20);
    check("s6_up_count", count, 1);
    rst = 1'b1;
    tick();
    check("s6_rst_count", count, 0);
    check("s6_rst_d", d, 1);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_err", err, 0);
    check("s6_rst_done", done, 0);
    rst = 1'b0;
    request(4'd3, 4'd6, 8'd1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check($sformatf("s6_count[%0d]", i), count, s6_cnt[i]);
      check($sformatf("s6_done[%0d]", i), done, s6_done[i]);
    end
    check("s6_err_end", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
